mem_access_stage: RTL and testbench

//   Memory stage of the 5-stage pipeline; replaces the single-cycle Memory + MWlatch pair.

---
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: runs loads and stores to an external data RAM over a req/ack handshake,
// stalls upstream while an access is outstanding, and drives the registered writeback bus.
module mem_access_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] mResult,
   input  logic [31:0]       mAddr,
   input  logic [3:0]        mRd,
   input  logic              mRdEnable,
   input  logic              mLoad,
   input  logic              mStore,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              Stall,
   output logic [DATA_W-1:0] wResult,
   output logic [3:0]        wRd,
   output logic              wRdEnable,
   output logic              mem_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] w_result_q, w_result_d;
   logic [3:0]        w_rd_q, w_rd_d;
   logic              w_rd_en_q, w_rd_en_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_q, load_d;
   logic              rd_en_q, rd_en_d;

   logic access;
   logic timeout_hit;
   logic unused_addr_bits;

   assign access           = mLoad | mStore;
   assign timeout_hit      = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign unused_addr_bits = ^mAddr;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      w_result_d  = w_result_q;
      w_rd_d      = w_rd_q;
      w_rd_en_d   = 1'b0;
      mem_err_d   = mem_err_q;
      cnt_d       = cnt_q;
      load_d      = load_q;
      rd_en_d     = rd_en_q;
      Stall       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (access) begin
               Stall       = 1'b1;
               state_d     = StWait;
               mem_req_d   = 1'b1;
               mem_we_d    = mStore & ~mLoad;
               mem_addr_d  = mAddr[ADDR_W-1:0];
               mem_wdata_d = mResult;
               w_rd_d      = mRd;
               load_d      = mLoad;
               rd_en_d     = mRdEnable;
               cnt_d       = '0;
               // Conflicting load+store runs as a load but is flagged.
               if (mLoad & mStore) begin
                  mem_err_d = 1'b1;
               end
            end else begin
               w_result_d = mResult;
               w_rd_d     = mRd;
               w_rd_en_d  = mRdEnable;
            end
         end
         StWait: begin
            // Ack takes priority over a coinciding timeout.
            Stall = ~mem_ack & ~timeout_hit;
            if (mem_ack) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               if (load_q) begin
                  w_result_d = mem_rdata;
                  w_rd_en_d  = rd_en_q;
               end
            end else if (timeout_hit) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               mem_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase

      if (rst) begin
         Stall = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         w_result_q  <= '0;
         w_rd_q      <= '0;
         w_rd_en_q   <= 1'b0;
         mem_err_q   <= 1'b0;
         cnt_q       <= '0;
         load_q      <= 1'b0;
         rd_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         w_result_q  <= w_result_d;
         w_rd_q      <= w_rd_d;
         w_rd_en_q   <= w_rd_en_d;
         mem_err_q   <= mem_err_d;
         cnt_q       <= cnt_d;
         load_q      <= load_d;
         rd_en_q     <= rd_en_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wResult   = w_result_q;
   assign wRd       = w_rd_q;
   assign wRdEnable = w_rd_en_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues random ops against a RAM responder with
// chosen ack latency, a monitor checks writebacks and RAM requests against queued expectations.
module tb_mem_access_stage;

   logic        clk;
   logic        rst;
   logic [31:0] mResult;
   logic [31:0] mAddr;
   logic [3:0]  mRd;
   logic        mRdEnable;
   logic        mLoad;
   logic        mStore;
   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        Stall;
   logic [31:0] wResult;
   logic [3:0]  wRd;
   logic        wRdEnable;
   logic        mem_err;

   mem_access_stage #(
      .DATA_W (32),
      .ADDR_W (10),
      .TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mResult  (mResult),
      .mAddr    (mAddr),
      .mRd      (mRd),
      .mRdEnable(mRdEnable),
      .mLoad    (mLoad),
      .mStore   (mStore),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .Stall    (Stall),
      .wResult  (wResult),
      .wRd      (wRd),
      .wRdEnable(wRdEnable),
      .mem_err  (mem_err)
   );

   localparam int NEVER = 255;

   int checks = 0;
   int errors = 0;

   logic [35:0] wb_q[$];   // {rd, data}
   logic [42:0] req_q[$];  // {we, addr, wdata}
   logic        err_exp = 1'b0;

   int          ram_lat = NEVER;
   logic [31:0] ram_rdata = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RAM responder: acks after ram_lat WAIT cycles; random stray acks while idle.
   initial begin
      int cnt;
      cnt       = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            mem_ack   = (cnt == ram_lat);
            mem_rdata = ram_rdata;
            cnt++;
         end else begin
            cnt       = 0;
            mem_ack   = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor: compares every writeback strobe and every new RAM request.
   initial begin
      logic        prev_req;
      logic [35:0] e;
      logic [42:0] r;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
         end else begin
            if (wRdEnable) begin
               if (wb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL wb_unexpected: got rd=%0d data=%0h expected none", wRd, wResult);
               end else begin
                  e = wb_q.pop_front();
                  chk("wb_data", 64'(wResult), 64'(e[31:0]));
                  chk("wb_rd", 64'(wRd), 64'(e[35:32]));
               end
            end
            if (mem_req && !prev_req) begin
               if (req_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL req_unexpected: got addr=%0h expected none", mem_addr);
               end else begin
                  r = req_q.pop_front();
                  chk("req_we", 64'(mem_we), 64'(r[42]));
                  chk("req_addr", 64'(mem_addr), 64'(r[41:32]));
                  chk("req_wdata", 64'(mem_wdata), 64'(r[31:0]));
               end
            end
            prev_req = mem_req;
         end
      end
   end

   // Issue one op, hold it through the stall, and check stall length and error flag.
   task automatic do_op(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] rd, input logic rden,
                        input int lat, input logic [31:0] rdata);
      int   stalls;
      int   n;
      int   exp_stalls;
      logic s;
      mResult   = data;
      mAddr     = addr;
      mRd       = rd;
      mRdEnable = rden;
      mLoad     = ld;
      mStore    = st;
      ram_lat   = lat;
      ram_rdata = rdata;
      if (ld || st) begin
         req_q.push_back({st & ~ld, addr[9:0], data});
         if (ld && st) err_exp = 1'b1;
         if (lat <= 15) begin
            exp_stalls = lat + 1;
            if (ld && rden) wb_q.push_back({rd, rdata});
         end else begin
            exp_stalls = 16;
            err_exp    = 1'b1;
         end
      end else begin
         exp_stalls = 0;
         if (rden) wb_q.push_back({rd, data});
      end
      stalls = 0;
      n      = 0;
      do begin
         @(negedge clk);
         s = Stall;
         if (s) stalls++;
         @(posedge clk);
         #1;
         n++;
      end while (s && n < 100);
      chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
      chk("mem_err", 64'(mem_err), 64'(err_exp));
   endtask

   initial begin
      rst       = 1'b1;
      mResult   = '0;
      mAddr     = '0;
      mRd       = '0;
      mRdEnable = 1'b0;
      mLoad     = 1'b1;
      mStore    = 1'b0;
      #1;
      chk("rst_stall", 64'(Stall), 64'(0));
      chk("rst_req", 64'(mem_req), 64'(0));
      chk("rst_we", 64'(mem_we), 64'(0));
      chk("rst_wren", 64'(wRdEnable), 64'(0));
      chk("rst_err", 64'(mem_err), 64'(0));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      chk("rst_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_wres", 64'(wResult), 64'(0));
      chk("rst_wrd", 64'(wRd), 64'(0));
      mLoad = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_op(1'b0, 1'b0, 32'h0, 32'h1234, 4'd3, 1'b1, NEVER, 32'h0);
      do_op(1'b1, 1'b0, 32'h40, 32'h0, 4'd7, 1'b1, 3, 32'hDEADBEEF);
      do_op(1'b0, 1'b1, 32'h3FF, 32'hA5A5A5A5, 4'd0, 1'b0, 1, 32'h0);
      do_op(1'b1, 1'b0, 32'h123, 32'h0, 4'd9, 1'b1, 15, 32'hCAFEF00D);
      do_op(1'b1, 1'b0, 32'h55, 32'h0, 4'd2, 1'b1, NEVER, 32'h0);
      do_op(1'b0, 1'b0, 32'h0, 32'h0BAD_F00D, 4'd5, 1'b1, NEVER, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int          kind;
         int          lsel;
         int          lat;
         logic        ld;
         logic        st;
         kind = $urandom_range(0, 15);
         lsel = $urandom_range(0, 9);
         lat  = (lsel <= 6) ? lsel : (lsel == 7) ? 15 : (lsel == 8) ? 14 : NEVER;
         ld   = (kind >= 6 && kind <= 10) || kind == 15;
         st   = (kind >= 11);
         do_op(ld, st, $urandom, $urandom, 4'($urandom), ld ? 1'b1 : 1'($urandom), lat,
               $urandom);
      end

      // Reset two cycles into WAIT abandons the load.
      mResult   = 32'h0;
      mAddr     = 32'h2AA;
      mRd       = 4'd4;
      mRdEnable = 1'b1;
      mLoad     = 1'b1;
      mStore    = 1'b0;
      ram_lat   = NEVER;
      req_q.push_back({1'b0, 10'h2AA, 32'h0});
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_req", 64'(mem_req), 64'(0));
      chk("midrst_stall", 64'(Stall), 64'(0));
      chk("midrst_wren", 64'(wRdEnable), 64'(0));
      mLoad     = 1'b0;
      mRdEnable = 1'b0;
      err_exp   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_op(1'b0, 1'b0, 32'h0, 32'h7777, 4'd8, 1'b1, NEVER, 32'h0);

      mRdEnable = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("wb_queue_empty", 64'(wb_q.size()), 64'(0));
      chk("req_queue_empty", 64'(req_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
